counter_holder_checker: RTL and testbench
=========================================

COUNTER_HOLDER_CHECKER -- requirements
Module: counter_holder_checker

Interface
REQ-001 SHALL have parameter WIDTH, default 3: width of a, b and dout.
REQ-002 SHALL have parameter CNT_W, default 8: width of pass_cnt and err_cnt.
REQ-003 SHALL have port clk, input, 1: single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst, input, 1: reset, asynchronous, active-high.
REQ-005 SHALL have port en, input, 1: enables checking.
REQ-006 SHALL have port select, input, 2: opcode driven to the counter/holder/adder; 00 add, 01 count, 10 hold, 11 hold.
REQ-007 SHALL have ports a and b, input, WIDTH each: adder operands.
REQ-008 SHALL have port dout, input, WIDTH: observed counter/holder/adder result.
REQ-009 SHALL have port pass_cnt, output, CNT_W: number of matching compares.
REQ-010 SHALL have port err_cnt, output, CNT_W: number of mismatching compares.
REQ-011 SHALL have port fail, output, 1: sticky flag, set by any mismatch.
REQ-012 SHALL have port synced, output, 1: high while in state CHECK.

Function
REQ-013 SHALL implement the states IDLE, SYNC, CHECK and HALT.
REQ-014 IDLE SHALL go to SYNC when en=1 and otherwise stay in IDLE.
REQ-015 SYNC SHALL do no compare, SHALL load exp with f(select, a, b, dout), and SHALL go to CHECK.
REQ-016 f SHALL be defined as follows, all arithmetic modulo 2^WIDTH with the carry discarded:
- 00 -> a+b
- 01 -> dout+1, so 7 wraps to 0
- 10 and 11 -> dout
REQ-017 In CHECK with en=1, on each edge the block SHALL compare dout with exp, SHALL increment pass_cnt or err_cnt, and SHALL reload exp with f(select, a, b, dout).
REQ-018 Because of REQ-017, the expected value SHALL be derived from the observed dout, so that one corrupted cycle yields exactly one error.
REQ-019 The latency SHALL be one cycle: the select, a and b sampled at edge N are checked against the dout sampled at edge N+1.
REQ-020 In any state other than IDLE, en=0 SHALL move the FSM to IDLE on the next edge with no compare in that cycle; en=0 SHALL take priority over a simultaneous mismatch.
REQ-021 The counters SHALL saturate at 2^CNT_W-1 and SHALL never wrap.
REQ-022 The counters and fail SHALL keep their values through IDLE and SHALL clear only on rst.
REQ-023 A mismatch SHALL set fail on the same edge that err_cnt increments.
REQ-024 synced SHALL be a registered output, equal to (state==CHECK).

Reset
REQ-025 rst=1 SHALL asynchronously force state to IDLE, exp to 0, pass_cnt to 0, err_cnt to 0, fail to 0 and synced to 0.
REQ-026 A reset asserted during CHECK SHALL discard the pending exp, and the block SHALL require a fresh SYNC after release.
REQ-027 After rst is released, the first state change SHALL occur on the first rising clk edge on which en=1.

Configuration
REQ-028 The macro CHC_STOP_ON_ERROR_EN SHALL select the error behaviour.
REQ-029 With CHC_STOP_ON_ERROR_EN defined, the first mismatch in CHECK SHALL move the FSM to HALT.
REQ-030 HALT SHALL freeze the counters and exp, and SHALL exit to IDLE only when en=0.
REQ-031 Without CHC_STOP_ON_ERROR_EN, HALT SHALL be unreachable and checking SHALL continue after mismatches.

Structure
REQ-032 The package chc_pkg SHALL hold the select encodings SEL_ADD=2'b00, SEL_CNT=2'b01 and SEL_HOLD=2'b10, and the state enum.
REQ-033 The sub-module chc_sat_counter SHALL be a CNT_W-bit saturating incrementer with async reset, instantiated twice, once for pass_cnt and once for err_cnt.

Verification
REQ-034 The bench SHALL cover this scenario: pulse rst with en=0 -> all outputs 0, state IDLE.
REQ-035 The bench SHALL cover this scenario: en=1, select=01, dout stepping 0,1,2,3 -> synced=1 after SYNC; pass_cnt=3, err_cnt=0.
REQ-036 The bench SHALL cover this scenario: select=01 with dout 6,7,0 -> the 7->0 wrap is accepted and no error is counted.
REQ-037 The bench SHALL cover this scenario: select=00 with a=2, b=3, then dout=5; then a=3, b=3, then dout=6 -> both pass; a forced dout=7 instead -> err_cnt=1, fail=1.
REQ-038 The bench SHALL cover this scenario: CNT_W=2 with 5 matching cycles -> pass_cnt holds at 3.
REQ-039 The bench SHALL cover this scenario: with CHC_STOP_ON_ERROR_EN, one mismatch followed by matches -> state HALT and err_cnt=1 frozen; en=0 -> IDLE.
REQ-040 The bench SHALL cover this scenario: assert rst mid-CHECK -> immediate clear; re-enable -> SYNC before any compare.

Source files
------------

// File: rtl/chc_pkg.sv
// Shared encodings for the counter/holder/adder checker: select opcodes and FSM states.
package chc_pkg;

   localparam logic [1:0] SEL_ADD  = 2'b00;
   localparam logic [1:0] SEL_CNT  = 2'b01;
   localparam logic [1:0] SEL_HOLD = 2'b10;

   typedef enum logic [1:0] {
      IDLE  = 2'b00,
      SYNC  = 2'b01,
      CHECK = 2'b10,
      HALT  = 2'b11
   } state_t;

endpackage

// File: rtl/chc_sat_counter.sv
// Saturating up-counter: increments on inc, sticks at all-ones, clears on async rst.
module chc_sat_counter #(
   parameter int CNT_W = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             inc,
   output logic [CNT_W-1:0] cnt
);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt <= '0;
      end else if (inc && (cnt != {CNT_W{1'b1}})) begin
         cnt <= cnt + CNT_W'(1);
      end
   end

endmodule

// File: rtl/counter_holder_checker.sv
// Checks a counter/holder/adder result one cycle after its operands, counting passes and errors.
// Define CHC_STOP_ON_ERROR_EN to halt checking on the first mismatch.
module counter_holder_checker
   import chc_pkg::*;
#(
   parameter int WIDTH = 3,
   parameter int CNT_W = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             en,
   input  logic [1:0]       select,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic [WIDTH-1:0] dout,
   output logic [CNT_W-1:0] pass_cnt,
   output logic [CNT_W-1:0] err_cnt,
   output logic             fail,
   output logic             synced
);

   state_t           state;
   state_t           state_nxt;
   logic [WIDTH-1:0] exp_val;
   logic [WIDTH-1:0] f_val;
   logic             cmp;
   logic             match;
   logic             pass_inc;
   logic             err_inc;

   // Prediction is built from the observed dout so one bad cycle costs one error.
   always_comb begin
      f_val = dout;
      case (select)
         SEL_ADD: f_val = a + b;
         SEL_CNT: f_val = dout + WIDTH'(1);
         default: f_val = dout;
      endcase
   end

   assign cmp      = (state == CHECK) && en;
   assign match    = (dout == exp_val);
   assign pass_inc = cmp && match;
   assign err_inc  = cmp && !match;

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:  if (en) state_nxt = SYNC;
         SYNC:  state_nxt = en ? CHECK : IDLE;
         CHECK: begin
            if (!en) begin
               state_nxt = IDLE;
            end
`ifdef CHC_STOP_ON_ERROR_EN
            else if (!match) begin
               state_nxt = HALT;
            end
`endif
         end
         HALT:  if (!en) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state  <= IDLE;
         synced <= 1'b0;
      end else begin
         state  <= state_nxt;
         synced <= (state_nxt == CHECK);
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         exp_val <= '0;
      end else if ((state == SYNC) || cmp) begin
         exp_val <= f_val;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         fail <= 1'b0;
      end else if (err_inc) begin
         fail <= 1'b1;
      end
   end

   chc_sat_counter #(.CNT_W(CNT_W)) u_pass_cnt (
      .clk (clk),
      .rst (rst),
      .inc (pass_inc),
      .cnt (pass_cnt)
   );

   chc_sat_counter #(.CNT_W(CNT_W)) u_err_cnt (
      .clk (clk),
      .rst (rst),
      .inc (err_inc),
      .cnt (err_cnt)
   );

endmodule

// File: tb/tb_counter_holder_checker.sv
// Directed bench: a default-width checker and a CNT_W=2 copy share all inputs.
module tb_counter_holder_checker;

`ifdef CHC_STOP_ON_ERROR_EN
   localparam bit STOP = 1'b1;
`else
   localparam bit STOP = 1'b0;
`endif

   logic       clk = 1'b0;
   logic       rst;
   logic       en;
   logic [1:0] sel;
   logic [2:0] a, b, dout;
   logic [7:0] pass_cnt, err_cnt;
   logic       fail, synced;
   logic [1:0] pass2, err2;
   logic       fail2, synced2;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   counter_holder_checker dut (
      .clk(clk), .rst(rst), .en(en), .select(sel), .a(a), .b(b), .dout(dout),
      .pass_cnt(pass_cnt), .err_cnt(err_cnt), .fail(fail), .synced(synced)
   );

   counter_holder_checker #(.WIDTH(3), .CNT_W(2)) dut2 (
      .clk(clk), .rst(rst), .en(en), .select(sel), .a(a), .b(b), .dout(dout),
      .pass_cnt(pass2), .err_cnt(err2), .fail(fail2), .synced(synced2)
   );

   typedef struct {
      logic       en;
      logic [1:0] sel;
      logic [2:0] a;
      logic [2:0] b;
      logic [2:0] dout;
      int         p;
      int         e;
      int         f;
      int         s;
   } vec_t;

   vec_t tbl[16];

   function automatic vec_t mk(logic e_i, logic [1:0] s_i, logic [2:0] a_i, logic [2:0] b_i,
                               logic [2:0] d_i, int p, int e, int f, int s);
      vec_t v;
      v.en = e_i; v.sel = s_i; v.a = a_i; v.b = b_i; v.dout = d_i;
      v.p = p; v.e = e; v.f = f; v.s = s;
      return v;
   endfunction

   function automatic int sat2(int x);
      return (x > 3) ? 3 : x;
   endfunction

   task automatic chk(string name, logic [31:0] act, logic [31:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s: got %0d, expected %0d", name, act, req);
      end
   endtask

   task automatic check_all(string tag, int p, int e, int f, int s);
      chk({tag, " pass_cnt"}, 32'(pass_cnt), p);
      chk({tag, " err_cnt"},  32'(err_cnt),  e);
      chk({tag, " fail"},     32'(fail),     f);
      chk({tag, " synced"},   32'(synced),   s);
      chk({tag, " pass_cnt w2"}, 32'(pass2), sat2(p));
      chk({tag, " err_cnt w2"},  32'(err2),  sat2(e));
      chk({tag, " fail w2"},     32'(fail2), f);
      chk({tag, " synced w2"},   32'(synced2), s);
   endtask

   task automatic drive(logic e_i, logic [1:0] s_i, logic [2:0] a_i, logic [2:0] b_i, logic [2:0] d_i);
      en = e_i; sel = s_i; a = a_i; b = b_i; dout = d_i;
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   initial begin
      // count run 0..7, wrap 7->0, adder 2+3 and 3+3, hold opcodes, then a forced 7 vs expected 6
      tbl[0]  = mk(1, 2'b01, 0, 0, 0,  0, 0, 0, 0);
      tbl[1]  = mk(1, 2'b01, 0, 0, 0,  0, 0, 0, 1);
      tbl[2]  = mk(1, 2'b01, 0, 0, 1,  1, 0, 0, 1);
      tbl[3]  = mk(1, 2'b01, 0, 0, 2,  2, 0, 0, 1);
      tbl[4]  = mk(1, 2'b01, 0, 0, 3,  3, 0, 0, 1);
      tbl[5]  = mk(1, 2'b01, 0, 0, 4,  4, 0, 0, 1);
      tbl[6]  = mk(1, 2'b01, 0, 0, 5,  5, 0, 0, 1);
      tbl[7]  = mk(1, 2'b01, 0, 0, 6,  6, 0, 0, 1);
      tbl[8]  = mk(1, 2'b01, 0, 0, 7,  7, 0, 0, 1);
      tbl[9]  = mk(1, 2'b00, 2, 3, 0,  8, 0, 0, 1);
      tbl[10] = mk(1, 2'b00, 3, 3, 5,  9, 0, 0, 1);
      tbl[11] = mk(1, 2'b11, 0, 0, 6, 10, 0, 0, 1);
      tbl[12] = mk(1, 2'b10, 0, 0, 6, 11, 0, 0, 1);
      tbl[13] = mk(1, 2'b00, 3, 3, 6, 12, 0, 0, 1);
      tbl[14] = mk(1, 2'b10, 0, 0, 7, 12, 1, 1, STOP ? 0 : 1);
      tbl[15] = mk(1, 2'b10, 0, 0, 7, STOP ? 12 : 13, 1, 1, STOP ? 0 : 1);

      drive(0, 2'b00, 0, 0, 0);
      rst = 1'b1;
      #12;
      rst = 1'b0;
      #1;
      check_all("reset", 0, 0, 0, 0);
      step();
      step();
      check_all("idle_en0", 0, 0, 0, 0);

      for (int i = 0; i < 16; i++) begin
         drive(tbl[i].en, tbl[i].sel, tbl[i].a, tbl[i].b, tbl[i].dout);
         step();
         check_all($sformatf("vec%0d", i), tbl[i].p, tbl[i].e, tbl[i].f, tbl[i].s);
      end

      if (STOP) begin
         // halted: stays out of CHECK while en=1 even with matching data
         drive(1, 2'b10, 0, 0, 7);
         step();
         step();
         check_all("halt_frozen", 12, 1, 1, 0);
         drive(0, 2'b10, 0, 0, 7);
         step();
         check_all("halt_exit", 12, 1, 1, 0);
      end else begin
         drive(1, 2'b10, 0, 0, 7);
         step();
         check_all("continue", 14, 1, 1, 1);
         // en=0 wins over a mismatching dout
         drive(0, 2'b10, 0, 0, 3);
         step();
         check_all("en0_prio", 14, 1, 1, 0);
      end

      begin
         int p0;
         p0 = STOP ? 12 : 14;
         step();
         check_all("idle_hold", p0, 1, 1, 0);
         drive(1, 2'b01, 0, 0, 0);
         step();
         check_all("resync_sync", p0, 1, 1, 0);
         step();
         check_all("resync_check", p0, 1, 1, 1);
         drive(1, 2'b01, 0, 0, 1);
         step();
         check_all("resync_pass", p0 + 1, 1, 1, 1);
      end

      // async reset mid-CHECK clears immediately, without a clock edge
      #2;
      rst = 1'b1;
      #1;
      check_all("mid_rst", 0, 0, 0, 0);
      drive(1, 2'b01, 0, 0, 5);
      @(negedge clk);
      rst = 1'b0;
      step();
      check_all("post_rst_sync", 0, 0, 0, 0);
      step();
      check_all("post_rst_load", 0, 0, 0, 1);
      drive(1, 2'b01, 0, 0, 6);
      step();
      check_all("post_rst_pass", 1, 0, 0, 1);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
